// File: rtl/col_collect_if.sv
// Column collector bus: per-column input strobes, serialised ready/valid output
// and sticky overflow flags.
interface col_collect_if #(
   parameter int unsigned COLS = 4,
   parameter int unsigned DW   = 2
);
   localparam int unsigned CW = $clog2(COLS);

   logic [COLS-1:0]         ival;
   logic [COLS-1:0][DW-1:0] idata;
   logic                    ovf_clr;
   logic                    ovalid;
   logic [DW-1:0]           odata;
   logic [CW-1:0]           ocol;
   logic                    oready;
   logic [COLS-1:0]         ovf;

   modport master (
      output ival, idata, ovf_clr, oready,
      input  ovalid, odata, ocol, ovf
   );

   modport slave (
      input  ival, idata, ovf_clr, oready,
      output ovalid, odata, ocol, ovf
   );
endinterface

// File: rtl/col_collect.sv
// Column result collector: per-column FIFOs drained round-robin onto one
// ready/valid stream tagged with the source column.
module col_collect #(
   parameter int unsigned COLS  = 4,
   parameter int unsigned DW    = 2,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rstb,
   col_collect_if.slave bus
);
   localparam int unsigned CW = $clog2(COLS);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned NW = PW + 1;

   logic [DW-1:0]   mem     [COLS][DEPTH];
   logic [PW-1:0]   wr_ptr  [COLS];
   logic [PW-1:0]   rd_ptr  [COLS];
   logic [NW-1:0]   count   [COLS];
   logic [CW-1:0]   last;

   logic            out_free;
   logic            found;
   logic [CW-1:0]   gnt;
   logic [CW-1:0]   cand;
   logic [COLS-1:0] push;
   logic [COLS-1:0] pop;
   logic [COLS-1:0] drop;

   assign out_free = !bus.ovalid || bus.oready;

   // Cyclic search for the first non-empty column after the last grant
   always_comb begin
      found = 1'b0;
      gnt   = '0;
      cand  = '0;
      for (int i = 1; i <= int'(COLS); i++) begin
         cand = CW'((int'(last) + i) % int'(COLS));
         if (!found && count[cand] != '0) begin
            found = 1'b1;
            gnt   = cand;
         end
      end
   end

   // A full column still accepts a write when its head leaves this cycle
   always_comb begin
      pop  = '0;
      push = '0;
      drop = '0;
      for (int c = 0; c < int'(COLS); c++) begin
         pop[c]  = out_free && found && (gnt == CW'(c));
         push[c] = bus.ival[c] && ((count[c] != NW'(DEPTH)) || pop[c]);
         drop[c] = bus.ival[c] && !push[c];
      end
   end

   // Storage array, no reset needed: occupancy gates every read
   always_ff @(posedge clk) begin
      for (int c = 0; c < int'(COLS); c++) begin
         if (push[c]) mem[c][wr_ptr[c]] <= bus.idata[c];
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         bus.ovalid <= 1'b0;
         bus.odata  <= '0;
         bus.ocol   <= '0;
         bus.ovf    <= '0;
         last       <= CW'(COLS - 1);
         for (int c = 0; c < int'(COLS); c++) begin
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
            count[c]  <= '0;
         end
      end else begin
         for (int c = 0; c < int'(COLS); c++) begin
            if (push[c]) wr_ptr[c] <= wr_ptr[c] + PW'(1);
            if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PW'(1);
            count[c] <= count[c] + NW'(push[c]) - NW'(pop[c]);
         end
         // A fresh drop outranks a simultaneous clear
         bus.ovf <= (bus.ovf & ~{COLS{bus.ovf_clr}}) | drop;
         if (out_free) begin
            bus.ovalid <= found;
            if (found) begin
               bus.odata <= mem[gnt][rd_ptr[gnt]];
               bus.ocol  <= gnt;
               last      <= gnt;
            end
         end
      end
   end
endmodule

// File: tb/tb_col_collect.sv
// Self-checking bench for col_collect: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_col_collect;
   localparam int COLS  = 4;
   localparam int DW    = 2;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rstb;
   always #5 clk = ~clk;

   col_collect_if #(.COLS(COLS), .DW(DW)) bus ();

   col_collect #(.COLS(COLS), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rstb (rstb),
      .bus  (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state
   logic [DW-1:0]   mq [COLS][$];
   int              m_last;
   logic            m_ovalid;
   logic [DW-1:0]   m_odata;
   int              m_ocol;
   logic [COLS-1:0] m_ovf;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < COLS; c++) mq[c].delete();
      m_last   = COLS - 1;
      m_ovalid = 1'b0;
      m_odata  = '0;
      m_ocol   = 0;
      m_ovf    = '0;
   endtask

   // One clock edge: grant from pre-edge contents, then accept writes
   task automatic model_edge();
      bit free;
      bit got;
      free = !m_ovalid || bus.oready;
      if (free) begin
         got = 0;
         for (int i = 1; i <= COLS; i++) begin
            int j;
            j = (m_last + i) % COLS;
            if (!got && mq[j].size() > 0) begin
               got = 1;
               m_odata = mq[j].pop_front();
               m_ocol  = j;
               m_last  = j;
            end
         end
         m_ovalid = got;
      end
      if (bus.ovf_clr) m_ovf = '0;
      for (int c = 0; c < COLS; c++) begin
         if (bus.ival[c]) begin
            if (mq[c].size() < DEPTH) mq[c].push_back(bus.idata[c]);
            else m_ovf[c] = 1'b1;
         end
      end
   endtask

   task automatic check_out(input string tag);
      chk({tag, "_ovalid"}, 32'(bus.ovalid), 32'(m_ovalid));
      if (m_ovalid) begin
         chk({tag, "_odata"}, 32'(bus.odata), 32'(m_odata));
         chk({tag, "_ocol"}, 32'(bus.ocol), 32'(m_ocol));
      end
      chk({tag, "_ovf"}, 32'(bus.ovf), 32'(m_ovf));
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      if (rstb) model_edge();
      else model_reset();
      @(negedge clk);
      check_out(tag);
   endtask

   task automatic drive(input logic [COLS-1:0] v, input logic [COLS*DW-1:0] d,
                        input logic rdy, input logic clr);
      bus.ival    = v;
      bus.idata   = d;
      bus.oready  = rdy;
      bus.ovf_clr = clr;
   endtask

   // Reset asserted between edges; output must fall with no clock
   task automatic async_reset(input string tag);
      drive('0, '0, 1'b1, 1'b0);
      #2;
      rstb = 1'b0;
      #1;
      chk({tag, "_ovalid"}, 32'(bus.ovalid), 32'(0));
      chk({tag, "_odata"}, 32'(bus.odata), 32'(0));
      chk({tag, "_ocol"}, 32'(bus.ocol), 32'(0));
      chk({tag, "_ovf"}, 32'(bus.ovf), 32'(0));
      model_reset();
      @(negedge clk);
      rstb = 1'b1;
   endtask

   logic [DW-1:0] held_data;
   logic [1:0]    held_col;

   initial begin
      rstb = 1'b0;
      drive('0, '0, 1'b1, 1'b0);
      model_reset();
      @(negedge clk);
      check_out("reset");
      rstb = 1'b1;

      // Single entry on column 2
      drive(4'b0100, {2'd0, 2'd3, 2'd0, 2'd0}, 1'b1, 1'b0);
      cyc("single_k1");
      chk("single_k1_valid", 32'(bus.ovalid), 32'(0));
      drive('0, '0, 1'b1, 1'b0);
      cyc("single_k2");
      chk("single_valid", 32'(bus.ovalid), 32'(1));
      chk("single_data", 32'(bus.odata), 32'(3));
      chk("single_col", 32'(bus.ocol), 32'(2));
      cyc("single_k3");
      chk("single_gone", 32'(bus.ovalid), 32'(0));
      chk("single_ovf", 32'(bus.ovf), 32'(0));

      // Round robin from a fresh reset
      async_reset("rst_rr");
      drive(4'b1111, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b1, 1'b0);
      cyc("rr_wr");
      drive('0, '0, 1'b1, 1'b0);
      for (int i = 0; i < COLS; i++) begin
         cyc("rr");
         chk("rr_valid", 32'(bus.ovalid), 32'(1));
         chk("rr_col", 32'(bus.ocol), 32'(i));
         chk("rr_data", 32'(bus.odata), 32'(i));
      end
      cyc("rr_end");
      chk("rr_end_valid", 32'(bus.ovalid), 32'(0));

      // Backpressure: hold for five cycles then drain in order
      async_reset("rst_bp");
      drive(4'b1111, {2'd2, 2'd1, 2'd3, 2'd0}, 1'b1, 1'b0);
      cyc("bp_wr");
      drive('0, '0, 1'b1, 1'b0);
      cyc("bp_first");
      held_data = bus.odata;
      held_col  = bus.ocol;
      chk("bp_first_col", 32'(held_col), 32'(0));
      drive('0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc("bp_stall");
         chk("bp_hold_valid", 32'(bus.ovalid), 32'(1));
         chk("bp_hold_data", 32'(bus.odata), 32'(held_data));
         chk("bp_hold_col", 32'(bus.ocol), 32'(held_col));
      end
      drive('0, '0, 1'b1, 1'b0);
      for (int i = 1; i < COLS; i++) begin
         cyc("bp_drain");
         chk("bp_drain_col", 32'(bus.ocol), 32'(i));
      end
      cyc("bp_end");
      chk("bp_end_valid", 32'(bus.ovalid), 32'(0));

      // Overflow on column 1 with output stalled
      async_reset("rst_ovf");
      for (int i = 0; i < 6; i++) begin
         drive(4'b0010, {2'd0, 2'd0, 2'(i), 2'd0}, 1'b0, 1'b0);
         cyc("ovf_fill");
         if (i == 4) chk("ovf_not_yet", 32'(bus.ovf), 32'(0));
      end
      chk("ovf_set", 32'(bus.ovf), 32'(4'b0010));
      chk("ovf_head", 32'(bus.odata), 32'(0));
      drive('0, '0, 1'b0, 1'b1);
      cyc("ovf_clr");
      chk("ovf_cleared", 32'(bus.ovf), 32'(0));
      drive(4'b0010, {2'd0, 2'd0, 2'd3, 2'd0}, 1'b0, 1'b1);
      cyc("ovf_clr_set");
      chk("ovf_set_wins", 32'(bus.ovf), 32'(4'b0010));
      drive('0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) cyc("ovf_drain");

      // Push into a full column in the cycle it is popped
      async_reset("rst_pp");
      for (int i = 0; i < 5; i++) begin
         drive(4'b0001, {2'd0, 2'd0, 2'd0, 2'(i)}, 1'b0, 1'b0);
         cyc("pp_fill");
      end
      drive(4'b0001, {2'd0, 2'd0, 2'd0, 2'd1}, 1'b1, 1'b0);
      cyc("pp_pushpop");
      chk("pp_ovf0", 32'(bus.ovf), 32'(0));
      drive('0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) cyc("pp_drain");

      // Reset while several columns hold entries
      async_reset("rst_ms0");
      drive(4'b1111, {2'd1, 2'd2, 2'd3, 2'd1}, 1'b1, 1'b0);
      cyc("ms_wr0");
      drive(4'b0111, {2'd0, 2'd2, 2'd1, 2'd3}, 1'b1, 1'b0);
      cyc("ms_wr1");
      drive('0, '0, 1'b1, 1'b0);
      cyc("ms_drain");
      chk("ms_pre_valid", 32'(bus.ovalid), 32'(1));
      async_reset("rst_mid");
      drive(4'b1000, {2'd2, 2'd0, 2'd0, 2'd0}, 1'b1, 1'b0);
      cyc("ms_new_k1");
      chk("ms_no_stale", 32'(bus.ovalid), 32'(0));
      drive('0, '0, 1'b1, 1'b0);
      cyc("ms_new_k2");
      chk("ms_new_valid", 32'(bus.ovalid), 32'(1));
      chk("ms_new_col", 32'(bus.ocol), 32'(3));
      chk("ms_new_data", 32'(bus.odata), 32'(2));
      cyc("ms_new_k3");
      chk("ms_new_end", 32'(bus.ovalid), 32'(0));

      // Random traffic against the model
      async_reset("rst_rand");
      for (int i = 0; i < 600; i++) begin
         drive(4'($urandom), 8'($urandom),
               (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 19) == 0));
         cyc("rand");
      end
      drive('0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) cyc("rand_drain");
      chk("rand_empty", 32'(bus.ovalid), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
